// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART0 transmit arbiter.
//   state_t : arbiter FSM state
//   rr_next : wrap-around increment for the round-robin pointer
//   DEF_*   : default configuration (4 requesters, 8-bit bytes, 1024-cycle lock timeout)
package uart_arb_pkg;

  localparam int unsigned DEF_NUM_REQ      = 4;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_LOCK_TIMEOUT = 1024;

  localparam int unsigned ID_W  = $clog2(DEF_NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DEF_LOCK_TIMEOUT);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Next index after ptr, wrapping to 0 at n
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return ((ptr + 32'd1) >= n) ? 32'd0 : (ptr + 32'd1);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the requesters, the arbiter and the UART TX core.
//   req_valid/req_data/req_last/req_ready : per-requester valid/ready byte streams
//   tx_valid/tx_data/tx_ready             : single stream into the UART TX core
// slave modport is the arbiter's view; master is the surrounding SoC wrapper.
interface uart_tx_arbiter_if
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_valid;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_ready;

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_valid, tx_data
  );

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_valid, tx_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first asserted req bit searching upward from ptr with wrap.
//   req   : request vector
//   ptr   : highest-priority index
//   found : any request asserted
//   idx   : chosen index (0 when nothing found)
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);

  // Scan ptr, ptr+1, ... mod N; the first hit wins
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[W'((32'(ptr) + i) % N)]) begin
        found = 1'b1;
        idx   = W'((32'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked arbiter sharing the UART0 transmitter between NUM_REQ requesters.
//   clk, resetn  : clock, asynchronous active-low reset
//   bus          : requester streams in, UART TX stream out (slave modport)
//   grant_id     : current or most recent owner
//   busy         : lock held
//   timeout_evt  : one-cycle pulse after a stalled owner is force-released
// The owner's stream is passed through combinationally while locked; nothing is buffered.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ      = DEF_NUM_REQ,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       resetn,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_evt
);

  localparam int unsigned GID_W = $clog2(NUM_REQ);
  localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(LOCK_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [GID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0]   grant_d;
  logic [GID_W-1:0]   pick_idx;
  logic [GID_W-1:0]   next_ptr;
  logic               pick_found;
  logic [TMO_W-1:0]   cnt_q, cnt_d;
  logic               timeout_c;
  logic               owner_valid;
  logic               owner_last;
  logic [DATA_W-1:0]  owner_data;

  rr_pick #(
    .N (NUM_REQ),
    .W (GID_W)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Owner's stream and the pointer value used on release
  assign owner_valid = bus.req_valid[grant_id];
  assign owner_last  = bus.req_last[grant_id];
  assign owner_data  = bus.req_data[32'(grant_id)*DATA_W +: DATA_W];
  assign next_ptr    = GID_W'(rr_next(32'(grant_id), NUM_REQ));
  assign busy        = (state_q == LOCKED);

  // Next state, lock counter and pass-through muxing
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_id;
    cnt_d         = cnt_q;
    timeout_c     = 1'b0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    bus.req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end

      LOCKED: begin
        bus.tx_valid            = owner_valid;
        bus.tx_data             = owner_data;
        bus.req_ready[grant_id] = bus.tx_ready;

        if (owner_valid && bus.tx_ready) begin
          cnt_d = '0;
          if (owner_last) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
          end
        end else if (!owner_valid) begin
          // Only an absent owner ages the lock; back-pressure never does
          if (cnt_q == TMO_MAX) begin
            timeout_c = 1'b1;
            state_d   = IDLE;
            rr_ptr_d  = next_ptr;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + TMO_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, pointer, grant and counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id    <= '0;
      cnt_q       <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id    <= grant_d;
      cnt_q       <= cnt_d;
      timeout_evt <= timeout_c;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (4 requesters, 8-bit bytes, 1024-cycle timeout).
// Inputs change 1 time unit after the rising edge; outputs are checked 3 units after it.
module tb_uart_tx_arbiter;

  logic       clk;
  logic       resetn;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout_evt;

  int vectors;
  int miscompares;
  logic bad;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .DATA_W       (8),
    .LOCK_TIMEOUT (1024)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_evt (timeout_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    bad           = 1'b0;
    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_ready  = 1'b0;

    // Reset values
    step(); step(); look();
    chk("rst_tx_valid",  32'(bus.tx_valid),  0);
    chk("rst_tx_data",   32'(bus.tx_data),   0);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_busy",      32'(busy),          0);
    chk("rst_grant",     32'(grant_id),      0);
    chk("rst_timeout",   32'(timeout_evt),   0);

    // Requester 2 alone: 0x41, 0x42, 0x43(last)
    step();
    resetn = 1'b1;
    bus.req_valid = 4'b0100;
    bus.req_data[16 +: 8] = 8'h41;
    bus.req_last  = 4'b0000;
    bus.tx_ready  = 1'b1;
    look();
    chk("t1_arb_tx_valid", 32'(bus.tx_valid), 0);
    chk("t1_arb_busy",     32'(busy),         0);
    step(); look();
    chk("t1_grant",     32'(grant_id),      2);
    chk("t1_busy",      32'(busy),          1);
    chk("t1_b0",        32'(bus.tx_data),   32'h41);
    chk("t1_req_ready", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_data[16 +: 8] = 8'h42;
    look();
    chk("t1_b1",       32'(bus.tx_data),  32'h42);
    chk("t1_b1_valid", 32'(bus.tx_valid), 1);
    step();
    bus.req_data[16 +: 8] = 8'h43;
    bus.req_last = 4'b0100;
    look();
    chk("t1_b2",      32'(bus.tx_data), 32'h43);
    chk("t1_b2_busy", 32'(busy),        1);
    step();
    bus.req_valid = 4'b0000;
    bus.req_last  = 4'b0000;
    look();
    chk("t1_end_busy",     32'(busy),         0);
    chk("t1_end_tx_valid", 32'(bus.tx_valid), 0);
    chk("t1_end_grant",    32'(grant_id),     2);
    // Pointer now 3: 3 beats 0 and 1
    bus.req_valid = 4'b1011;
    bus.req_last  = 4'b1111;
    bus.req_data[24 +: 8] = 8'hD3;
    step(); look();
    chk("t1_rr3_grant", 32'(grant_id),    3);
    chk("t1_rr3_data",  32'(bus.tx_data), 32'hD3);
    step(); look();
    chk("t1_rr3_idle", 32'(busy), 0);

    // Reset, then all four requesters with 1-byte packets
    resetn = 1'b0;
    step(); step();
    resetn = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_last  = 4'b1111;
    bus.req_data  = 32'hA3A2A1A0;
    look();
    chk("t2_start_idle", 32'(busy), 0);
    for (int k = 0; k < 5; k++) begin
      step(); look();
      chk("t2_grant",     32'(grant_id),      k % 4);
      chk("t2_data",      32'(bus.tx_data),   32'hA0 + (k % 4));
      chk("t2_req_ready", 32'(bus.req_ready), 1 << (k % 4));
      step(); look();
      chk("t2_gap_busy",     32'(busy),         0);
      chk("t2_gap_tx_valid", 32'(bus.tx_valid), 0);
    end

    // Owner 1 sends 0x10 then stalls while 3 waits
    bus.req_valid = 4'b1010;
    bus.req_last  = 4'b1000;
    bus.req_data[8 +: 8]  = 8'h10;
    bus.req_data[24 +: 8] = 8'h33;
    step(); look();
    chk("t3_grant", 32'(grant_id),      1);
    chk("t3_data",  32'(bus.tx_data),   32'h10);
    chk("t3_ready", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = 4'b1000;
    look();
    chk("t3_stall_tx_valid", 32'(bus.tx_valid), 0);
    chk("t3_stall_busy",     32'(busy),         1);
    bad = 1'b0;
    for (int j = 2; j <= 1024; j++) begin
      step(); look();
      if (bus.tx_valid !== 1'b0 || busy !== 1'b1 || timeout_evt !== 1'b0) bad = 1'b1;
    end
    chk("t3_stall_window", 32'(bad), 0);
    step(); look();
    chk("t3_timeout_evt",  32'(timeout_evt),  1);
    chk("t3_release_busy", 32'(busy),         0);
    chk("t3_release_txv",  32'(bus.tx_valid), 0);
    step(); look();
    chk("t3_evt_cleared", 32'(timeout_evt), 0);
    chk("t3_next_grant",  32'(grant_id),    3);
    chk("t3_next_data",   32'(bus.tx_data), 32'h33);
    step();
    bus.req_valid = 4'b0000;
    look();
    chk("t3_done_busy", 32'(busy),        0);
    chk("t3_done_evt",  32'(timeout_evt), 0);

    // Owner 0 back-pressured for 5000 cycles
    bus.req_valid = 4'b0101;
    bus.req_last  = 4'b0001;
    bus.req_data[0 +: 8]  = 8'h5A;
    bus.req_data[16 +: 8] = 8'h77;
    bus.tx_ready  = 1'b0;
    step(); look();
    chk("t4_grant",    32'(grant_id),      0);
    chk("t4_tx_valid", 32'(bus.tx_valid),  1);
    chk("t4_ready",    32'(bus.req_ready), 0);
    bad = 1'b0;
    for (int j = 0; j < 5000; j++) begin
      step(); look();
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h5A || busy !== 1'b1 ||
          timeout_evt !== 1'b0 || grant_id !== 2'd0) bad = 1'b1;
    end
    chk("t4_hold_window", 32'(bad), 0);
    step();
    bus.tx_ready = 1'b1;
    look();
    chk("t4_release_ready", 32'(bus.req_ready), 32'b0001);
    chk("t4_release_data",  32'(bus.tx_data),   32'h5A);
    step(); look();
    chk("t4_done_busy", 32'(busy), 0);
    step(); look();
    chk("t4_next_grant", 32'(grant_id),    2);
    chk("t4_next_data",  32'(bus.tx_data), 32'h77);

    // Asynchronous reset in the middle of owner 2's packet
    #1;
    resetn = 1'b0;
    #1;
    chk("t5_rst_tx_valid", 32'(bus.tx_valid),  0);
    chk("t5_rst_tx_data",  32'(bus.tx_data),   0);
    chk("t5_rst_ready",    32'(bus.req_ready), 0);
    chk("t5_rst_busy",     32'(busy),          0);
    chk("t5_rst_grant",    32'(grant_id),      0);
    step(); step();
    resetn = 1'b1;
    look();
    chk("t5_post_idle", 32'(busy), 0);
    step(); look();
    chk("t5_post_grant", 32'(grant_id),    0);
    chk("t5_post_data",  32'(bus.tx_data), 32'h5A);
    chk("t5_post_busy",  32'(busy),        1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single SoC UART0 transmitter between NUM_REQ byte-stream requesters (CPU console, debug monitor, boot status, ...).
- Grants are packet-locked: the owner keeps the transmitter until it sends a byte flagged last, or until it stalls past LOCK_TIMEOUT.
- Sits between the requesters and the UART TX core's valid/ready byte input, inside the SoC wrapper clock domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, byte width forwarded to UART TX
- LOCK_TIMEOUT, 1024, idle cycles of the owner (valid low mid-packet) before the lock is forcibly released (>=2)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  byte is the final byte of the packet
- req_ready  out  NUM_REQ  per-requester byte accepted
- tx_valid  out  1  byte valid to UART TX core
- tx_data  out  DATA_W  byte to UART TX core
- tx_ready  in  1  UART TX core accepts the byte
- grant_id  out  $clog2(NUM_REQ)  current or last owner index
- busy  out  1  high while the lock is held
- timeout_evt  out  1  one-cycle pulse when a lock is force-released

Behaviour:
- Reset (async, resetn=0): state=IDLE, rr_ptr=0, grant_id=0, busy=0, timeout_evt=0, counter=0. Outputs req_ready=0, tx_valid=0, tx_data=0. Reset mid-packet discards the lock silently; no byte is emitted.
- States: IDLE, LOCKED.
- IDLE:
  - tx_valid=0 and all req_ready=0.
  - If any req_valid is high, pick the first asserted index searching upward from rr_ptr with wrap (rr_ptr has highest priority).
  - Register the pick as grant_id and go to LOCKED on the next edge. Arbitration costs exactly one cycle.
- LOCKED, owner o=grant_id:
  - Combinational pass-through: tx_valid=req_valid[o], tx_data=req_data[o], req_ready[o]=tx_ready. Every other req_ready is 0. busy=1.
  - A transfer occurs when tx_valid && tx_ready.
  - Transfer with req_last[o]=1: next state IDLE, rr_ptr=(o+1) mod NUM_REQ, counter cleared.
  - Transfer without last: stay LOCKED, counter cleared.
  - req_valid[o]=0: counter increments. When the counter reaches LOCK_TIMEOUT-1, pulse timeout_evt for one cycle, go IDLE, set rr_ptr=(o+1) mod NUM_REQ, clear the counter.
  - Cycles with req_valid[o]=1 and tx_ready=0 do not count. A back-pressured owner is never timed out, so tx_valid never drops while a byte is pending.
- Other-requester changes while LOCKED are ignored. Their valid/data must be held by the requester; the arbiter stores nothing.
- A single-byte packet (last on the first byte) returns to IDLE after that transfer. Back-to-back packets always have exactly one IDLE cycle between them.
- grant_id holds its value through IDLE until the next grant.
- Counter width is $clog2(LOCK_TIMEOUT). It saturates and never wraps.
- Fairness: each requester waits at most NUM_REQ-1 packets (or timeouts) before it is granted.

Decomposition:
- Package uart_arb_pkg:
  - state enum {IDLE, LOCKED}
  - localparams ID_W=$clog2(NUM_REQ) and CNT_W=$clog2(LOCK_TIMEOUT)
  - rr_next helper function (wrap increment)
- Sub-module rr_pick: purely combinational, inputs req vector and rr_ptr, outputs found and index.
- The FSM, counter and muxing live in uart_tx_arbiter.

Test Plan:
- Requester 2 alone sends 3 bytes 0x41,0x42,0x43 with last on 0x43, tx_ready=1 -> grant_id=2, tx_data sequence 0x41,0x42,0x43 on 3 consecutive cycles after the 1-cycle arbitration, busy falls after 0x43, rr_ptr=3.
- All 4 requesters valid with 1-byte packets, rr_ptr=0 -> grant order 0,1,2,3,0; each grant is separated by one IDLE cycle.
- Owner 1 sends 0x10 (not last) then deasserts valid for LOCK_TIMEOUT cycles while requester 3 waits -> timeout_evt pulses exactly once, the next grant is 3, and no byte from 1 leaks out.
- Owner 0 with tx_ready=0 for 5000 cycles, valid held -> no timeout, tx_valid stays 1 with stable data; the byte transfers when tx_ready rises.
- Assert resetn=0 mid-packet of owner 2 -> all outputs 0 immediately. After release, requester 0 (if valid) is granted first.
